rr_mux_reg: RTL and testbench

- Parametrised N:1 multiplexer with a registered output and valid/ready handshakes on every input channel and on the output.
- Replaces the combinational 2:1 select with arbitration. A runtime mode input chooses round-robin or fixed-priority.
- Sits between several producer channels and a single downstream consumer.
- Adds one cycle of latency and sustains full throughput of one beat per clock.

---
 rtl/rr_mux_reg.sv | 87 ++++++++
 tb/tb_rr_mux_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_reg.sv
// N:1 multiplexer with a registered output, valid/ready handshakes on every
// channel, and runtime-selectable round-robin or fixed-priority arbitration.
// One cycle of latency, one beat per clock sustained when downstream is ready.
// Note: in_ready_o depends combinationally on out_ready_i.
module rr_mux_reg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         in_valid_i,
  input  logic [NUM_CH*WIDTH-1:0]   in_data_i,
  output logic [NUM_CH-1:0]         in_ready_o,
  input  logic                      rr_en_i,
  output logic                      out_valid_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic [SEL_W-1:0]          out_sel_o,
  input  logic                      out_ready_i
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [SEL_W-1:0] ptr_q;

  logic             load;
  logic             any_v;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] ptr_nxt;
  int unsigned      idx;

  assign load  = !out_valid_q || out_ready_i;
  assign start = rr_en_i ? ptr_q : '0;

  // Scan channels from the start index, wrapping modulo NUM_CH; first valid wins.
  always_comb begin
    any_v = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(start) + i) % NUM_CH;
      if (!any_v && in_valid_i[idx]) begin
        any_v = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  // Pointer moves to the slot just past the winner, wrapping to 0.
  always_comb begin
    ptr_nxt = (win == SEL_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
  end

  // Grant only the winner, and only when the output register can take a beat.
  always_comb begin
    in_ready_o = '0;
    if (load && any_v) begin
      in_ready_o = NUM_CH'(1) << win;
    end
  end

  // Output register and round-robin pointer; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      out_valid_q <= any_v;
      if (any_v) begin
        out_data_q <= in_data_i[32'(win) * WIDTH +: WIDTH];
        out_sel_q  <= win;
        if (rr_en_i) begin
          ptr_q <= ptr_nxt;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbiter and register.
module tb_rr_mux_reg;
  localparam int W = 8;
  localparam int N = 4;
  localparam int SW = 2;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_ready;
  logic              rr_en;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_sel;
  logic              out_ready;

  rr_mux_reg #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .rr_en_i     (rr_en),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  bit        m_valid;
  int        m_data;
  int        m_sel;
  int        m_ptr;
  bit [N-1:0] m_xfer;
  bit        track_starve;
  int        waits [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic tick();
    int  s;
    int  w;
    int  k;
    bit  ld;
    logic [N-1:0] exp_ready;
    #1;
    s = rr_en ? m_ptr : 0;
    w = -1;
    for (int i = 0; i < N; i++) begin
      k = (s + i) % N;
      if (w < 0 && in_valid[k]) w = k;
    end
    ld = !m_valid || out_ready;
    exp_ready = (ld && w >= 0) ? N'(1 << w) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), m_data);
    check("out_sel", 32'(out_sel), m_sel);
    if (track_starve && reset_n && ld && w >= 0) begin
      check("starve", waits[w], (waits[w] <= N - 1) ? waits[w] : N - 1);
      for (int c = 0; c < N; c++) begin
        if (c == w || !in_valid[c]) waits[c] = 0;
        else waits[c]++;
      end
    end
    @(posedge clk);
    m_xfer = '0;
    if (!reset_n) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    end else if (ld) begin
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_data = int'(in_data[w*W +: W]);
        m_sel  = w;
        m_xfer = exp_ready;
        if (rr_en) m_ptr = (w + 1) % N;
      end
    end
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  initial begin
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_xfer = '0;
    track_starve = 0;
    for (int c = 0; c < N; c++) waits[c] = 0;

    // 1. Reset and idle.
    reset_n = 1'b0; rr_en = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
    for (int c = 0; c < N; c++) set_data(c, W'(8'hA0 + c));
    @(posedge clk); #1;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_sel", 32'(out_sel), 0);
    reset_n = 1'b1;
    #1 check("first_ready", 32'(in_ready), 32'h1);

    // 2. Round-robin rotation, no bubbles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_valid", 32'(out_valid), 1);
      check("rr_sel", 32'(out_sel), i % 4);
      check("rr_data", 32'(out_data), 32'hA0 + (i % 4));
    end

    // 3. Fixed priority.
    rr_en = 1'b0; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fp_sel", 32'(out_sel), 1);
      check("fp_rdy3", 32'(in_ready[3]), 0);
    end

    // 4. Back-pressure.
    in_valid = 4'b0001; set_data(0, 8'h55);
    tick();
    set_data(0, 8'h66);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 32'(in_ready), 0);
      tick();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'h55);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next", 32'(out_data), 32'h66);

    // 5. Wrap and sparse requests.
    rr_en = 1'b1; in_valid = 4'b0100; set_data(2, 8'hA2);
    tick();
    check("wrap_c2", 32'(out_sel), 2);
    in_valid = 4'b0011; set_data(0, 8'hA0);
    tick();
    check("wrap_c0", 32'(out_sel), 0);
    tick();
    check("wrap_c1", 32'(out_sel), 1);
    in_valid = 4'hF;
    tick();
    check("wrap_ptr2", 32'(out_sel), 2);

    // 6. Reset mid-stall.
    in_valid = 4'b0001; set_data(0, 8'h77);
    tick();
    in_valid = '0; out_ready = 1'b0;
    tick();
    check("ms_held", 32'(out_valid), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; out_ready = 1'b1;
    check("ms_valid", 32'(out_valid), 0);
    tick();
    check("ms_gone", 32'(out_valid), 0);
    in_valid = 4'hF;
    tick();
    check("ms_ptr0", 32'(out_sel), 0);

    // Randomized traffic obeying the producer rules.
    for (int phase = 0; phase < 2; phase++) begin
      track_starve = (phase == 0);
      rr_en = 1'b1;
      for (int c = 0; c < N; c++) waits[c] = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        for (int c = 0; c < N; c++) begin
          if (m_xfer[c] || !in_valid[c]) begin
            in_valid[c] = ($urandom_range(0, 2) != 0);
            set_data(c, W'($urandom));
          end
        end
        out_ready = ($urandom_range(0, 3) != 0);
        if (phase == 1 && $urandom_range(0, 9) == 0) rr_en = ~rr_en;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
